charmap_fill_dma: RTL and testbench

CHARMAP_FILL_DMA -- requirements
Module: charmap_fill_dma

---
 rtl/charmap_fill_dma_pkg.sv | 27 ++
 rtl/charmap_port_arb.sv | 27 ++
 rtl/charmap_fill_dma.sv | 139 +++++++++++++
 tb/tb_charmap_fill_dma.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/charmap_fill_dma_pkg.sv
// charmap_fill_dma_pkg: register map, CTRL fields, target masks and FSM states for the fill DMA
package charmap_fill_dma_pkg;

    localparam logic [2:0] REG_DST_LO = 3'd0;
    localparam logic [2:0] REG_DST_HI = 3'd1;
    localparam logic [2:0] REG_LEN_LO = 3'd2;
    localparam logic [2:0] REG_LEN_HI = 3'd3;
    localparam logic [2:0] REG_VALUE  = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;

    localparam int CTRL_START_BIT = 7;
    localparam int CTRL_MASK_W    = 3;

    localparam logic [2:0] TGT_CHAR = 3'b001;
    localparam logic [2:0] TGT_FG   = 3'b010;
    localparam logic [2:0] TGT_BG   = 3'b100;
    localparam logic [2:0] TGT_ALL  = TGT_CHAR | TGT_FG | TGT_BG;

    localparam int LEN_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/charmap_port_arb.sv
// charmap_port_arb: combinational CPU-over-DMA mux onto the shared video RAM CPU-side ports
module charmap_port_arb
    import charmap_fill_dma_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_din_i,
    input  logic [2:0]        cpu_we_i,
    input  logic              dma_req_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [7:0]        dma_din_i,
    input  logic [2:0]        dma_we_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_din_o,
    output logic [2:0]        ram_we_o
);

    // CPU wins every cycle it asks; with no DMA the bus tracks the CPU with writes off
    always_comb begin
        ram_addr_o = (cpu_req_i || !dma_req_i) ? cpu_addr_i : dma_addr_i;
        ram_din_o  = (cpu_req_i || !dma_req_i) ? cpu_din_i : dma_din_i;
        ram_we_o   = cpu_req_i ? cpu_we_i : (dma_req_i ? (dma_we_i & TGT_ALL) : 3'b000);
    end

endmodule

// File: rtl/charmap_fill_dma.sv
// charmap_fill_dma: register-programmed fill engine writing a constant into char/fg/bg video RAM
module charmap_fill_dma
    import charmap_fill_dma_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              reg_cs,
    input  logic              reg_wr,
    input  logic [2:0]        reg_addr,
    input  logic [7:0]        reg_din,
    output logic [7:0]        reg_dout,
    input  logic              cpu_vram_req,
    input  logic [ADDR_W-1:0] cpu_vram_addr,
    input  logic [7:0]        cpu_vram_din,
    input  logic [2:0]        cpu_vram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic [2:0]        ram_we,
    output logic              busy,
    output logic              done_pulse
);

    state_e             state_q, state_d;
    logic [7:0]         dst_lo_q, dst_lo_d;
    logic [2:0]         dst_hi_q, dst_hi_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [3:0]         len_hi_q, len_hi_d;
    logic [7:0]         value_q, value_d;
    logic [2:0]         mask_q, mask_d;
    logic               done_flag_q, done_flag_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               reg_we, start, dma_req;
    logic [2:0]         start_mask, arb_we;
    logic [LEN_W-1:0]   len;

    assign busy       = state_q != ST_IDLE;
    assign done_pulse = state_q == ST_DONE;
    assign reg_we     = reg_cs && reg_wr && !busy;
    assign start      = reg_we && reg_addr == REG_CTRL && reg_din[CTRL_START_BIT];
    assign start_mask = reg_din[CTRL_MASK_W-1:0] & TGT_ALL;
    assign len        = {len_hi_q, len_lo_q};
    assign dma_req    = state_q == ST_FILL;

    // Register file next state: host writes land only while the engine is idle
    always_comb begin
        dst_lo_d = (reg_we && reg_addr == REG_DST_LO) ? reg_din : dst_lo_q;
        dst_hi_d = (reg_we && reg_addr == REG_DST_HI) ? reg_din[2:0] : dst_hi_q;
        len_lo_d = (reg_we && reg_addr == REG_LEN_LO) ? reg_din : len_lo_q;
        len_hi_d = (reg_we && reg_addr == REG_LEN_HI) ? reg_din[3:0] : len_hi_q;
        value_d  = (reg_we && reg_addr == REG_VALUE) ? reg_din : value_q;
        mask_d   = (reg_we && reg_addr == REG_CTRL) ? start_mask : mask_q;
    end

    // Fill sequencing: a write retires only in cycles the CPU leaves the RAM port free
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = ADDR_W'({dst_hi_q, dst_lo_q});
                    rem_d   = len;
                    state_d = (len != '0 && start_mask != '0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                if (!cpu_vram_req) begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        done_flag_d = (state_d == ST_DONE && state_q != ST_DONE) ? 1'b1 : (start ? 1'b0 : done_flag_q);
    end

    // State and register storage, cleared asynchronously so a reset aborts any fill at once
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dst_lo_q    <= '0;
            dst_hi_q    <= '0;
            len_lo_q    <= '0;
            len_hi_q    <= '0;
            value_q     <= '0;
            mask_q      <= '0;
            done_flag_q <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            dst_lo_q    <= dst_lo_d;
            dst_hi_q    <= dst_hi_d;
            len_lo_q    <= len_lo_d;
            len_hi_q    <= len_hi_d;
            value_q     <= value_d;
            mask_q      <= mask_d;
            done_flag_q <= done_flag_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
        end
    end

    // Register readback; CTRL exposes live status alongside the stored mask
    always_comb begin
        case (reg_addr)
            REG_DST_LO: reg_dout = dst_lo_q;
            REG_DST_HI: reg_dout = {5'b0, dst_hi_q};
            REG_LEN_LO: reg_dout = len_lo_q;
            REG_LEN_HI: reg_dout = {4'b0, len_hi_q};
            REG_VALUE:  reg_dout = value_q;
            REG_CTRL:   reg_dout = {busy, done_flag_q, 3'b000, mask_q};
            default:    reg_dout = 8'h00;
        endcase
    end

    charmap_port_arb #(.ADDR_W(ADDR_W)) u_arb (
        .cpu_req_i  (cpu_vram_req),
        .cpu_addr_i (cpu_vram_addr),
        .cpu_din_i  (cpu_vram_din),
        .cpu_we_i   (cpu_vram_we),
        .dma_req_i  (dma_req),
        .dma_addr_i (cnt_q),
        .dma_din_i  (value_q),
        .dma_we_i   (mask_q),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_we_o   (arb_we)
    );

    assign ram_we = arb_we & {3{reset_n}};

endmodule

// File: tb/tb_charmap_fill_dma.sv
// tb_charmap_fill_dma: queue-based reference model plus directed literal checks for the fill DMA
module tb_charmap_fill_dma;

    localparam int AW = 11;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          reg_cs = 1'b0;
    logic          reg_wr = 1'b0;
    logic [2:0]    reg_addr = 3'd0;
    logic [7:0]    reg_din = 8'h00;
    logic [7:0]    reg_dout;
    logic          cpu_vram_req = 1'b0;
    logic [AW-1:0] cpu_vram_addr = '0;
    logic [7:0]    cpu_vram_din = 8'h00;
    logic [2:0]    cpu_vram_we = 3'b000;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [2:0]    ram_we;
    logic          busy;
    logic          done_pulse;

    int   tests = 0;
    int   fails = 0;
    bit   rnd_cpu = 0;
    int   dut_cnt [2048];

    int         q_addr [$];
    logic [7:0] m_reg [0:7];
    logic [2:0] m_mask;
    bit         m_flag;
    bit         m_done;

    charmap_fill_dma #(.ADDR_W(AW)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .reg_cs        (reg_cs),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_din       (reg_din),
        .reg_dout      (reg_dout),
        .cpu_vram_req  (cpu_vram_req),
        .cpu_vram_addr (cpu_vram_addr),
        .cpu_vram_din  (cpu_vram_din),
        .cpu_vram_we   (cpu_vram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_we        (ram_we),
        .busy          (busy),
        .done_pulse    (done_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a fill is a queue of pending addresses, drained one per CPU-free cycle
    always @(negedge clk_sys) begin
        logic [7:0] exp_rd;
        bit         m_busy;
        bit         nxt_done;
        int         len;
        int         dst;
        if (!reset_n) begin
            q_addr.delete();
            m_done = 0;
            m_flag = 0;
            m_mask = 3'b000;
            foreach (m_reg[i]) m_reg[i] = 8'h00;
            chk("rst_we", 32'(ram_we), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done_pulse), 0);
            chk("rst_dout", 32'(reg_dout), 0);
        end else begin
            m_busy = q_addr.size() > 0 || m_done;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done_pulse", 32'(done_pulse), 32'(m_done));
            exp_rd = reg_addr < 3'd5 ? m_reg[reg_addr] : (reg_addr == 3'd5 ? {m_busy, m_flag, 3'b000, m_mask} : 8'h00);
            chk("reg_dout", 32'(reg_dout), 32'(exp_rd));
            if (cpu_vram_req) begin
                chk("cpu_addr", 32'(ram_addr), 32'(cpu_vram_addr));
                chk("cpu_din", 32'(ram_din), 32'(cpu_vram_din));
                chk("cpu_we", 32'(ram_we), 32'(cpu_vram_we));
            end else if (q_addr.size() > 0) begin
                chk("dma_addr", 32'(ram_addr), 32'(q_addr[0]));
                chk("dma_din", 32'(ram_din), 32'(m_reg[4]));
                chk("dma_we", 32'(ram_we), 32'(m_mask));
            end else begin
                chk("idle_we", 32'(ram_we), 0);
                chk("idle_addr", 32'(ram_addr), 32'(cpu_vram_addr));
            end
            if (ram_we != 3'b000 && !cpu_vram_req) dut_cnt[int'(ram_addr)]++;
            nxt_done = 0;
            if (q_addr.size() > 0) begin
                if (!cpu_vram_req) begin
                    void'(q_addr.pop_front());
                    nxt_done = q_addr.size() == 0;
                end
            end else if (!m_done && reg_cs && reg_wr) begin
                case (reg_addr)
                    3'd0: m_reg[0] = reg_din;
                    3'd1: m_reg[1] = {5'b0, reg_din[2:0]};
                    3'd2: m_reg[2] = reg_din;
                    3'd3: m_reg[3] = {4'b0, reg_din[3:0]};
                    3'd4: m_reg[4] = reg_din;
                    3'd5: begin
                        m_mask = reg_din[2:0];
                        if (reg_din[7]) begin
                            m_flag = 0;
                            len = {m_reg[3][3:0], m_reg[2]};
                            dst = {m_reg[1][2:0], m_reg[0]};
                            if (len != 0 && m_mask != 3'b000)
                                for (int k = 0; k < len; k++) q_addr.push_back((dst + k) % 2048);
                            else
                                nxt_done = 1;
                        end
                    end
                    default: ;
                endcase
            end
            if (nxt_done) m_flag = 1;
            m_done = nxt_done;
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
        if (rnd_cpu) begin
            cpu_vram_req  = $urandom_range(0, 3) == 0;
            cpu_vram_addr = AW'($urandom);
            cpu_vram_din  = 8'($urandom);
            cpu_vram_we   = 3'($urandom);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        reg_cs   = 1'b1;
        reg_wr   = 1'b1;
        reg_addr = a;
        reg_din  = d;
        step();
        reg_cs = 1'b0;
        reg_wr = 1'b0;
    endtask

    task automatic fill(input int dst, input int len, input logic [7:0] val, input logic [2:0] m);
        wr_reg(3'd0, 8'(dst));
        wr_reg(3'd1, 8'(dst >> 8));
        wr_reg(3'd2, 8'(len));
        wr_reg(3'd3, 8'(len >> 8));
        wr_reg(3'd4, val);
        wr_reg(3'd5, {5'b10000, m});
    endtask

    task automatic wait_idle(input bit meddle);
        int guard = 0;
        while (busy && guard < 6000) begin
            if (meddle && $urandom_range(0, 5) == 0) wr_reg(3'($urandom_range(0, 7)), 8'($urandom));
            else step();
            guard++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic clr_cnt();
        foreach (dut_cnt[i]) dut_cnt[i] = 0;
    endtask

    initial begin
        int exp_a [4];
        cpu_vram_req = 1'b1;
        cpu_vram_we  = 3'b111;
        reg_addr     = 3'd5;
        #2;
        chk("lit_rst_we", 32'(ram_we), 0);
        chk("lit_rst_ctrl", 32'(reg_dout), 0);
        cpu_vram_req = 1'b0;
        cpu_vram_we  = 3'b000;
        repeat (3) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        step();

        // Plain 5-cell char fill
        clr_cnt();
        fill(0, 5, 8'h20, 3'b001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            chk("lit23_addr", 32'(ram_addr), 32'(i));
            chk("lit23_we", 32'(ram_we), 32'h1);
            chk("lit23_din", 32'(ram_din), 32'h20);
            step();
        end
        @(negedge clk_sys);
        chk("lit23_done", 32'(done_pulse), 1);
        step();
        @(negedge clk_sys);
        chk("lit23_busy_after", 32'(busy), 0);
        chk("lit23_ctrl", 32'(reg_dout), 32'h41);

        // Same fill with CPU stealing cycles 2 and 3
        clr_cnt();
        fill(0, 5, 8'h20, 3'b001);
        @(negedge clk_sys);
        chk("lit24_first", 32'(ram_addr), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            cpu_vram_req  = 1'b1;
            cpu_vram_addr = AW'(11'h123);
            cpu_vram_din  = 8'h5A;
            cpu_vram_we   = 3'b100;
            @(negedge clk_sys);
            chk("lit24_cpu_addr", 32'(ram_addr), 32'h123);
            chk("lit24_cpu_we", 32'(ram_we), 32'h4);
            chk("lit24_cpu_din", 32'(ram_din), 32'h5A);
        end
        step();
        cpu_vram_req = 1'b0;
        cpu_vram_we  = 3'b000;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk_sys);
            chk("lit24_addr", 32'(ram_addr), 32'(i));
            step();
        end
        @(negedge clk_sys);
        chk("lit24_done", 32'(done_pulse), 1);
        for (int i = 0; i < 5; i++) chk("lit24_once", 32'(dut_cnt[i]), 1);
        step();

        // Address wrap at the top of RAM
        exp_a = '{32'h7FE, 32'h7FF, 32'h000, 32'h001};
        fill(32'h7FE, 4, 8'hAA, 3'b111);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            chk("lit25_addr", 32'(ram_addr), 32'(exp_a[i]));
            chk("lit25_we", 32'(ram_we), 32'h7);
            step();
        end
        @(negedge clk_sys);
        chk("lit25_done", 32'(done_pulse), 1);
        step();

        // Zero length: straight to DONE, no writes
        fill(32'h10, 0, 8'h33, 3'b010);
        @(negedge clk_sys);
        chk("lit26_busy", 32'(busy), 1);
        chk("lit26_done", 32'(done_pulse), 1);
        chk("lit26_we", 32'(ram_we), 0);
        chk("lit26_ctrl_done", 32'(reg_dout), 32'hC2);
        step();
        @(negedge clk_sys);
        chk("lit26_busy_after", 32'(busy), 0);
        chk("lit26_ctrl", 32'(reg_dout), 32'h42);
        step();

        // Writes and START while busy are ignored
        fill(32'h100, 6, 8'h11, 3'b011);
        wr_reg(3'd4, 8'h99);
        wr_reg(3'd5, 8'h87);
        wait_idle(0);
        step();
        reg_addr = 3'd4;
        #1 chk("lit27_value", 32'(reg_dout), 32'h11);
        reg_addr = 3'd5;
        #1 chk("lit27_ctrl", 32'(reg_dout), 32'h43);

        // Reset in the middle of a fill
        clr_cnt();
        fill(32'h200, 20, 8'h77, 3'b111);
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("lit27_rst_we", 32'(ram_we), 0);
        chk("lit27_rst_busy", 32'(busy), 0);
        chk("lit27_rst_done", 32'(done_pulse), 0);
        chk("lit27_kept", 32'(dut_cnt[32'h202]), 1);
        chk("lit27_not_reached", 32'(dut_cnt[32'h203]), 0);
        step();
        reset_n = 1'b1;
        step();
        step();

        // Randomized fills under CPU contention and busy-time register traffic
        rnd_cpu = 1;
        for (int n = 0; n < 30; n++) begin
            fill(int'($urandom_range(0, 2047)), int'($urandom_range(0, 30)), 8'($urandom), 3'($urandom_range(0, 7)));
            wait_idle(1);
            repeat ($urandom_range(0, 3)) step();
        end
        fill(int'($urandom_range(0, 2047)), 2050, 8'h5C, 3'b001);
        wait_idle(1);
        rnd_cpu = 0;
        cpu_vram_req = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
